// File: rtl/bus_controller_rr.sv
// Shared-bus controller: N masters to N slaves, round-robin arbitration,
// burst ownership and segment-fault reporting on bus protocol errors.
module bus_controller_rr #(
  parameter int N_MASTER = 4,
  parameter int N_SLAVE  = 8,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ACK_TO   = 16,
  parameter int BUSY_TO  = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_MASTER*AW-1:0] master_addr,
  input  logic [N_MASTER*DW-1:0] master_wdata,
  input  logic [N_MASTER-1:0]    master_rreq,
  input  logic [N_MASTER-1:0]    master_wreq,
  output logic [N_MASTER-1:0]    master_acc,
  output logic [DW-1:0]          master_rdata,
  output logic                   master_busy,
  output logic [AW-1:0]          slave_addr,
  output logic [DW-1:0]          slave_wdata,
  output logic                   slave_rreq,
  output logic                   slave_wreq,
  input  logic [N_SLAVE*DW-1:0]  slave_rdata,
  input  logic [N_SLAVE-1:0]     slave_busy,
  input  logic [N_SLAVE-1:0]     slave_ack,
  output logic                   seg_fault,
  output logic [2:0]             seg_reason,
  output logic [AW-1:0]          seg_addr
);

  localparam int GW  = $clog2(N_MASTER);
  localparam int SW  = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
  localparam int CW  = $clog2(N_SLAVE + 1);
  localparam int AKW = $clog2(ACK_TO + 1);
  localparam int BSW = $clog2(BUSY_TO + 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    FAULT
  } state_t;

  state_t              state;
  logic [GW-1:0]       gidx;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       win;
  logic [GW-1:0]       k;
  logic                found;
  logic [N_MASTER-1:0] req;
  logic [AKW-1:0]      ack_cnt;
  logic [BSW-1:0]      busy_cnt;
  logic [CW-1:0]       n_ack;
  logic [SW-1:0]       sel;
  logic                one_ack;
  logic                sel_busy;
  logic [DW-1:0]       sel_rdata;
  logic                g_rreq;
  logic                g_wreq;
  logic                g_req;
  logic [AW-1:0]       g_addr;
  logic [DW-1:0]       g_wdata;
  logic [2:0]          reason;
  logic                own;
  logic                hold;

  assign req = master_rreq | master_wreq;

  // rotating search starting just after the last owner
  always_comb begin
    win   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= N_MASTER; i++) begin
      k = GW'((int'(last_grant) + i) % N_MASTER);
      if (!found && req[k]) begin
        found = 1'b1;
        win   = k;
      end
    end
  end

  always_comb begin
    n_ack = '0;
    sel   = '0;
    for (int j = 0; j < N_SLAVE; j++) begin
      if (slave_ack[j]) begin
        n_ack = n_ack + CW'(1);
        sel   = SW'(j);
      end
    end
  end

  always_comb begin
    sel_busy  = 1'b0;
    sel_rdata = '0;
    for (int j = 0; j < N_SLAVE; j++) begin
      if (sel == SW'(j)) begin
        sel_busy  = slave_busy[j];
        sel_rdata = slave_rdata[j*DW +: DW];
      end
    end
  end

  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    g_rreq  = 1'b0;
    g_wreq  = 1'b0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (gidx == GW'(i)) begin
        g_addr  = master_addr[i*AW +: AW];
        g_wdata = master_wdata[i*DW +: DW];
        g_rreq  = master_rreq[i];
        g_wreq  = master_wreq[i];
      end
    end
  end

  assign g_req   = g_rreq | g_wreq;
  assign one_ack = (n_ack == CW'(1));
  assign own     = (state == OWN);
  assign hold    = (state != IDLE);

  assign slave_addr   = hold ? g_addr : '0;
  assign slave_wdata  = hold ? g_wdata : '0;
  assign slave_rreq   = own & g_rreq;
  assign slave_wreq   = own & g_wreq;
  assign master_rdata = (own && one_ack) ? sel_rdata : '0;
  assign master_busy  = own & (~one_ack | sel_busy);

  // ordered: illegal request > multi-ack > no-ack > busy timeout
  always_comb begin
    reason = 3'd0;
    if (g_rreq && g_wreq)
      reason = 3'd3;
    else if (n_ack > CW'(1))
      reason = 3'd2;
    else if (n_ack == '0 && ack_cnt >= AKW'(ACK_TO - 1))
      reason = 3'd1;
    else if (one_ack && sel_busy &&
             busy_cnt >= BSW'(BUSY_TO - 1))
      reason = 3'd4;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      master_acc <= '0;
      gidx       <= '0;
      last_grant <= GW'(N_MASTER - 1);
      ack_cnt    <= '0;
      busy_cnt   <= '0;
      seg_fault  <= 1'b0;
      seg_reason <= 3'd0;
      seg_addr   <= '0;
    end else begin
      seg_fault <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            master_acc <= N_MASTER'(1) << win;
            gidx       <= win;
            ack_cnt    <= '0;
            busy_cnt   <= '0;
            state      <= OWN;
          end
        end
        OWN: begin
          if (!g_req) begin
            master_acc <= '0;
            last_grant <= gidx;
            state      <= IDLE;
          end else if (reason != 3'd0) begin
            seg_fault  <= 1'b1;
            seg_reason <= reason;
            seg_addr   <= g_addr;
            state      <= FAULT;
          end else begin
            if (n_ack != '0)
              ack_cnt <= '0;
            else if (ack_cnt != AKW'(ACK_TO))
              ack_cnt <= ack_cnt + AKW'(1);
            if (!(one_ack && sel_busy))
              busy_cnt <= '0;
            else if (busy_cnt != BSW'(BUSY_TO))
              busy_cnt <= busy_cnt + BSW'(1);
          end
        end
        FAULT: begin
          if (!g_req) begin
            master_acc <= '0;
            last_grant <= gidx;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_controller_rr.sv
// Directed bench for bus_controller_rr with an expectation queue.
// Expectations are queued as stimulus is driven and popped on sampling.
module tb_bus_controller_rr;

  localparam int NM      = 4;
  localparam int NS      = 8;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int ACK_TO  = 16;
  localparam int BUSY_TO = 255;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NM*AW-1:0] master_addr = '0;
  logic [NM*DW-1:0] master_wdata = '0;
  logic [NM-1:0]    master_rreq = '0;
  logic [NM-1:0]    master_wreq = '0;
  logic [NM-1:0]    master_acc;
  logic [DW-1:0]    master_rdata;
  logic             master_busy;
  logic [AW-1:0]    slave_addr;
  logic [DW-1:0]    slave_wdata;
  logic             slave_rreq;
  logic             slave_wreq;
  logic [NS*DW-1:0] slave_rdata = '0;
  logic [NS-1:0]    slave_busy = '0;
  logic [NS-1:0]    slave_ack = '0;
  logic             seg_fault;
  logic [2:0]       seg_reason;
  logic [AW-1:0]    seg_addr;

  bus_controller_rr #(
    .N_MASTER(NM), .N_SLAVE(NS), .AW(AW), .DW(DW),
    .ACK_TO(ACK_TO), .BUSY_TO(BUSY_TO)
  ) dut (
    .clk(clk), .reset(reset),
    .master_addr(master_addr), .master_wdata(master_wdata),
    .master_rreq(master_rreq), .master_wreq(master_wreq),
    .master_acc(master_acc), .master_rdata(master_rdata),
    .master_busy(master_busy),
    .slave_addr(slave_addr), .slave_wdata(slave_wdata),
    .slave_rreq(slave_rreq), .slave_wreq(slave_wreq),
    .slave_rdata(slave_rdata), .slave_busy(slave_busy),
    .slave_ack(slave_ack),
    .seg_fault(seg_fault), .seg_reason(seg_reason),
    .seg_addr(seg_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   beats = 0;
  bit   count_en = 1'b0;

  always @(posedge clk)
    if (count_en && reset && (slave_wreq || slave_rreq) &&
        $onehot(slave_ack) && !master_busy)
      beats++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL queue_empty observed=%h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic set_m(input int i, input logic [31:0] a,
                       input logic [31:0] d, input logic r,
                       input logic w);
    master_addr[i*AW +: AW]  = a;
    master_wdata[i*DW +: DW] = d;
    master_rreq[i]           = r;
    master_wreq[i]           = w;
  endtask

  initial begin
    int n;
    for (int s = 0; s < NS; s++)
      slave_rdata[s*DW +: DW] = (s == 0) ? 32'h2333 : 32'h1000 + s;

    // reset state
    #2;
    push("rst_acc", 0); push("rst_fault", 0); push("rst_reason", 0);
    push("rst_saddr", 0); push("rst_rreq", 0); push("rst_busy", 0);
    push("rst_rdata", 0);
    tick(); tick();
    pop_check(master_acc); pop_check(seg_fault); pop_check(seg_reason);
    pop_check(seg_addr); pop_check(slave_rreq); pop_check(master_busy);
    pop_check(master_rdata);
    reset = 1'b1;
    tick();

    // single read by master 0
    set_m(0, 32'h10, 0, 1, 0);
    slave_ack = 8'h01;
    push("rd_acc", 4'b0001); push("rd_rreq", 1);
    push("rd_rdata", 32'h2333); push("rd_busy", 0);
    push("rd_addr", 32'h10);
    tick(); #1;
    pop_check(master_acc); pop_check(slave_rreq);
    pop_check(master_rdata); pop_check(master_busy);
    pop_check(slave_addr);
    set_m(0, 0, 0, 0, 0);
    slave_ack = '0;
    push("rd_rel", 0);
    tick();
    pop_check(master_acc);

    // round robin from a fresh pointer
    reset = 1'b0; #1; reset = 1'b1;
    slave_ack = 8'h01;
    set_m(0, 32'h20, 0, 1, 0);
    set_m(1, 32'h24, 0, 1, 0);
    set_m(2, 32'h28, 0, 1, 0);
    push("rr_g0", 4'b0001); push("rr_gap0", 0);
    push("rr_g1", 4'b0010); push("rr_gap1", 0);
    push("rr_g2", 4'b0100); push("rr_gap2", 0);
    push("rr_wrap", 4'b0001);
    tick(); pop_check(master_acc);
    master_rreq[0] = 1'b0;
    tick(); pop_check(master_acc);
    tick(); pop_check(master_acc);
    master_rreq[1] = 1'b0;
    tick(); pop_check(master_acc);
    tick(); pop_check(master_acc);
    master_rreq[2] = 1'b0;
    tick(); pop_check(master_acc);
    master_rreq[0] = 1'b1;
    master_rreq[1] = 1'b1;
    tick(); pop_check(master_acc);
    master_rreq = '0;
    slave_ack = '0;
    tick(); tick();

    // burst write, master 2 to slave 2, with a 2-cycle stall
    beats = 0;
    count_en = 1'b1;
    slave_ack = 8'h04;
    set_m(2, 32'h100, 32'h23, 0, 1);
    push("bw_acc", 4'b0100); push("bw_a0", 32'h100);
    push("bw_d0", 32'h23); push("bw_wreq", 1); push("bw_busy0", 0);
    tick(); #1;
    pop_check(master_acc); pop_check(slave_addr);
    pop_check(slave_wdata); pop_check(slave_wreq);
    pop_check(master_busy);
    tick();
    set_m(2, 32'h104, 32'h24, 0, 1);
    slave_busy = 8'h04;
    push("bw_a1", 32'h104); push("bw_stall", 1); push("bw_hold", 4'b0100);
    #1;
    pop_check(slave_addr); pop_check(master_busy); pop_check(master_acc);
    tick();
    push("bw_stall2", 1);
    pop_check(master_busy);
    tick();
    slave_busy = '0;
    push("bw_go", 0); push("bw_d1", 32'h24);
    #1;
    pop_check(master_busy); pop_check(slave_wdata);
    tick();
    set_m(2, 32'h108, 32'h25, 0, 1);
    push("bw_a2", 32'h108); push("bw_d2", 32'h25);
    #1;
    pop_check(slave_addr); pop_check(slave_wdata);
    tick();
    set_m(2, 0, 0, 0, 0);
    push("bw_held", 4'b0100); push("bw_beats", 3);
    pop_check(master_acc); pop_check(beats);
    count_en = 1'b0;
    push("bw_rel", 0);
    tick();
    pop_check(master_acc);
    slave_ack = '0;
    tick();

    // no ack from any slave
    set_m(1, 32'hDEAD0000, 0, 1, 0);
    push("na_acc", 4'b0010); push("na_busy", 1);
    push("na_rdata", 0); push("na_rreq", 1);
    tick(); #1;
    pop_check(master_acc); pop_check(master_busy);
    pop_check(master_rdata); pop_check(slave_rreq);
    n = 0;
    while (!seg_fault && n < 300) begin
      tick();
      n++;
    end
    push("na_cycles", ACK_TO); push("na_reason", 1);
    push("na_addr", 32'hDEAD0000); push("na_busy_f", 0);
    push("na_rreq_f", 0); push("na_acc_f", 4'b0010);
    pop_check(n); pop_check(seg_reason); pop_check(seg_addr);
    pop_check(master_busy); pop_check(slave_rreq);
    pop_check(master_acc);
    set_m(3, 32'h30, 0, 1, 0);
    push("na_pulse", 0); push("na_keep", 1); push("na_wait", 4'b0010);
    tick();
    pop_check(seg_fault); pop_check(seg_reason); pop_check(master_acc);
    master_rreq[1] = 1'b0;
    push("na_gap", 0); push("na_next", 4'b1000);
    tick(); pop_check(master_acc);
    tick(); pop_check(master_acc);
    master_rreq[3] = 1'b0;
    tick();

    // two slaves ack together
    set_m(0, 32'h40, 0, 1, 0);
    slave_ack = 8'h03;
    push("ma_acc", 4'b0001); push("ma_nofault", 0);
    push("ma_fault", 1); push("ma_reason", 2); push("ma_addr", 32'h40);
    tick();
    pop_check(master_acc); pop_check(seg_fault);
    tick();
    pop_check(seg_fault); pop_check(seg_reason); pop_check(seg_addr);
    set_m(0, 0, 0, 0, 0);
    slave_ack = '0;
    tick(); tick();

    // read and write together outranks multi-ack
    set_m(1, 32'h80, 0, 1, 1);
    slave_ack = 8'h03;
    push("rw_acc", 4'b0010); push("rw_fault", 1); push("rw_reason", 3);
    tick(); pop_check(master_acc);
    tick(); pop_check(seg_fault); pop_check(seg_reason);
    set_m(1, 0, 0, 0, 0);
    slave_ack = '0;
    tick(); tick();

    // selected slave stuck busy
    set_m(2, 32'h200, 0, 1, 0);
    slave_ack = 8'h04;
    slave_busy = 8'h04;
    push("bt_acc", 4'b0100);
    tick(); pop_check(master_acc);
    n = 0;
    while (!seg_fault && n < 400) begin
      tick();
      n++;
    end
    push("bt_cycles", BUSY_TO); push("bt_reason", 4);
    push("bt_addr", 32'h200);
    pop_check(n); pop_check(seg_reason); pop_check(seg_addr);
    set_m(2, 0, 0, 0, 0);
    slave_ack = '0;
    slave_busy = '0;
    tick(); tick();

    // asynchronous reset in the middle of a burst
    set_m(3, 32'h300, 32'h77, 0, 1);
    slave_ack = 8'h08;
    push("ar_acc", 4'b1000);
    tick(); pop_check(master_acc);
    tick();
    reset = 1'b0;
    push("ar_acc0", 0); push("ar_wreq", 0); push("ar_saddr", 0);
    push("ar_fault", 0); push("ar_reason", 0); push("ar_faddr", 0);
    #1;
    pop_check(master_acc); pop_check(slave_wreq); pop_check(slave_addr);
    pop_check(seg_fault); pop_check(seg_reason); pop_check(seg_addr);
    set_m(0, 32'h50, 0, 1, 0);
    set_m(3, 32'h300, 0, 1, 0);
    slave_ack = 8'h01;
    @(posedge clk);
    #1;
    reset = 1'b1;
    push("ar_prio", 4'b0001);
    tick(); pop_check(master_acc);
    master_rreq = '0;
    slave_ack = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
